if_id_stall_regs: RTL and testbench

- Receiving end of the load-use hazard interface.
- Owns the PC register, the IF/ID pipeline register and the ID/EX control-field register.
- Consumes the hazard unit's stall controls (PCWrite, IFtoIDWrite, ControlSel) and the branch flush.
- Feeds IF_ID_Rs/IF_ID_Rt back to the hazard unit and keeps saturating stall and flush event counters for performance debug.

---
 rtl/pipeline_pkg.sv | 31 +++
 rtl/sat_counter.sv | 29 ++
 rtl/if_id_stall_regs.sv | 130 +++++++++++++
 tb/tb_if_id_stall_regs.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants, field positions and select encodings for the IF/ID
// stall-register slice of the pipeline.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam int          REG_ADDR_W = 5;
  localparam int          CTRL_W_DEF = 9;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef enum logic [1:0] {
    PC_SEL_HOLD  = 2'd0,
    PC_SEL_INC   = 2'd1,
    PC_SEL_REDIR = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    IFID_SEL_HOLD  = 2'd0,
    IFID_SEL_LOAD  = 2'd1,
    IFID_SEL_FLUSH = 2'd2
  } ifid_sel_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that clears on synchronous active-low reset and sticks at
// its maximum value instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == MAX) ? v : v + W'(1);
  endfunction

  logic [W-1:0] count_p0;

  always_ff @(posedge clk) begin
    if (!rst)
      count_p0 <= '0;
    else if (inc)
      count_p0 <= sat_inc(count_p0);
  end

  assign count = count_p0;

endmodule

// File: rtl/if_id_stall_regs.sv
// PC, IF/ID and ID/EX control registers steered by the load-use hazard
// controls and the branch flush, with stall/flush event counters.
module if_id_stall_regs
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = CTRL_W_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCWrite,
  input  logic                  IFtoIDWrite,
  input  logic                  ControlSel,
  input  logic                  Flush,
  input  logic [31:0]           BranchTarget,
  input  logic [31:0]           Instr_in,
  input  logic [CTRL_W-1:0]     Ctrl_in,
  output logic [31:0]           PC,
  output logic [31:0]           IF_ID_Instr,
  output logic [31:0]           IF_ID_PCPlus4,
  output logic                  IF_ID_Valid,
  output logic [REG_ADDR_W-1:0] IF_ID_Rs,
  output logic [REG_ADDR_W-1:0] IF_ID_Rt,
  output logic [CTRL_W-1:0]     ID_EX_Ctrl,
  output logic [CNT_W-1:0]      StallCount,
  output logic [CNT_W-1:0]      FlushCount
);

  logic [31:0]       pc_p0;
  logic [31:0]       pc_inc_p0;
  pc_sel_e           pc_sel;
  ifid_sel_e         ifid_sel;

  logic [31:0]       instr_p1;
  logic [31:0]       pcplus4_p1;
  logic              vld_p1;

  logic [CTRL_W-1:0] ctrl_p2;
  logic              bubble;

  assign pc_inc_p0 = pc_p0 + PC_STEP;

  // Flush wins over both write enables; the two enables act independently.
  always_comb begin
    pc_sel   = PC_SEL_HOLD;
    ifid_sel = IFID_SEL_HOLD;
    if (Flush)
      pc_sel = PC_SEL_REDIR;
    else if (PCWrite)
      pc_sel = PC_SEL_INC;
    if (Flush)
      ifid_sel = IFID_SEL_FLUSH;
    else if (IFtoIDWrite)
      ifid_sel = IFID_SEL_LOAD;
  end

  // ---- stage p0: fetch address ----
  always_ff @(posedge clk) begin
    if (!rst)
      pc_p0 <= RESET_PC;
    else begin
      case (pc_sel)
        PC_SEL_REDIR: pc_p0 <= word_align(BranchTarget);
        PC_SEL_INC:   pc_p0 <= pc_inc_p0;
        default:      pc_p0 <= pc_p0;
      endcase
    end
  end

  // ---- stage p1: IF/ID register ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_p1   <= NOP_INSTR;
      pcplus4_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      case (ifid_sel)
        IFID_SEL_FLUSH: begin
          instr_p1   <= NOP_INSTR;
          pcplus4_p1 <= '0;
          vld_p1     <= 1'b0;
        end
        IFID_SEL_LOAD: begin
          instr_p1   <= Instr_in;
          pcplus4_p1 <= pc_inc_p0;
          vld_p1     <= 1'b1;
        end
        default: begin
          instr_p1   <= instr_p1;
          pcplus4_p1 <= pcplus4_p1;
          vld_p1     <= vld_p1;
        end
      endcase
    end
  end

  // ---- stage p2: ID/EX control; an empty IF/ID also yields a bubble ----
  assign bubble = !(ControlSel && vld_p1);

  always_ff @(posedge clk) begin
    if (!rst)
      ctrl_p2 <= '0;
    else
      ctrl_p2 <= bubble ? '0 : Ctrl_in;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!ControlSel),
    .count (StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (Flush),
    .count (FlushCount)
  );

  assign PC            = pc_p0;
  assign IF_ID_Instr   = instr_p1;
  assign IF_ID_PCPlus4 = pcplus4_p1;
  assign IF_ID_Valid   = vld_p1;
  assign IF_ID_Rs      = instr_p1[RS_MSB:RS_LSB];
  assign IF_ID_Rt      = instr_p1[RT_MSB:RT_LSB];
  assign ID_EX_Ctrl    = ctrl_p2;

endmodule

// File: tb/tb_if_id_stall_regs.sv
// Directed-vector scoreboard bench: default instance for pipeline behaviour,
// second instance (RESET_PC=FFFF_FFFC, CNT_W=3) for PC wrap and saturation.
module tb_if_id_stall_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCWrite = 1'b1, IFtoIDWrite = 1'b1, ControlSel = 1'b1, Flush = 1'b0;
  logic [31:0] BranchTarget = 32'h0, Instr_in = 32'h0;
  logic [8:0]  Ctrl_in = 9'h0;

  logic [31:0] pc_a, instr_a, pc4_a, pc_b, instr_b, pc4_b;
  logic        vld_a, vld_b;
  logic [4:0]  rs_a, rt_a, rs_b, rt_b;
  logic [8:0]  ctrl_a, ctrl_b;
  logic [15:0] st_a, fl_a;
  logic [2:0]  st_b, fl_b;

  always #5 clk = ~clk;

  if_id_stall_regs u_dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IFtoIDWrite(IFtoIDWrite),
    .ControlSel(ControlSel), .Flush(Flush), .BranchTarget(BranchTarget),
    .Instr_in(Instr_in), .Ctrl_in(Ctrl_in), .PC(pc_a), .IF_ID_Instr(instr_a),
    .IF_ID_PCPlus4(pc4_a), .IF_ID_Valid(vld_a), .IF_ID_Rs(rs_a), .IF_ID_Rt(rt_a),
    .ID_EX_Ctrl(ctrl_a), .StallCount(st_a), .FlushCount(fl_a)
  );

  if_id_stall_regs #(.RESET_PC(32'hFFFF_FFFC), .CTRL_W(9), .CNT_W(3)) u_alt (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IFtoIDWrite(IFtoIDWrite),
    .ControlSel(ControlSel), .Flush(Flush), .BranchTarget(BranchTarget),
    .Instr_in(Instr_in), .Ctrl_in(Ctrl_in), .PC(pc_b), .IF_ID_Instr(instr_b),
    .IF_ID_PCPlus4(pc4_b), .IF_ID_Valid(vld_b), .IF_ID_Rs(rs_b), .IF_ID_Rt(rt_b),
    .ID_EX_Ctrl(ctrl_b), .StallCount(st_b), .FlushCount(fl_b)
  );

  typedef struct {
    int          id;
    logic        alt;
    logic [31:0] pc, instr, pc4;
    logic        vld;
    logic [4:0]  rs, rt;
    logic [8:0]  ctrl;
    logic [15:0] st, fl;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nbad = 0;

  task automatic check(input int id, input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      nbad++;
      $display("FAIL vec%0d %s: got %h expected %h", id, name, act, req);
    end
  endtask

  // Drive one vector before the next rising edge and queue its post-edge result.
  task automatic vec(input int id, input logic r, pw, iw, cs, fl,
                     input logic [31:0] bt, ins, input logic [8:0] ct,
                     input logic alt, input logic [31:0] epc, einstr, epc4,
                     input logic evld, input logic [8:0] ectrl,
                     input logic [15:0] est, efl);
    exp_t e;
    @(negedge clk);
    rst = r; PCWrite = pw; IFtoIDWrite = iw; ControlSel = cs; Flush = fl;
    BranchTarget = bt; Instr_in = ins; Ctrl_in = ct;
    e.id = id; e.alt = alt; e.pc = epc; e.instr = einstr; e.pc4 = epc4;
    e.vld = evld; e.rs = einstr[25:21]; e.rt = einstr[20:16];
    e.ctrl = ectrl; e.st = est; e.fl = efl;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      nvec++;
      if (!e.alt) begin
        check(e.id, "PC", pc_a, e.pc);
        check(e.id, "IF_ID_Instr", instr_a, e.instr);
        check(e.id, "IF_ID_PCPlus4", pc4_a, e.pc4);
        check(e.id, "IF_ID_Valid", {31'b0, vld_a}, {31'b0, e.vld});
        check(e.id, "IF_ID_Rs", {27'b0, rs_a}, {27'b0, e.rs});
        check(e.id, "IF_ID_Rt", {27'b0, rt_a}, {27'b0, e.rt});
        check(e.id, "ID_EX_Ctrl", {23'b0, ctrl_a}, {23'b0, e.ctrl});
        check(e.id, "StallCount", {16'b0, st_a}, {16'b0, e.st});
        check(e.id, "FlushCount", {16'b0, fl_a}, {16'b0, e.fl});
      end else begin
        check(e.id, "alt PC", pc_b, e.pc);
        check(e.id, "alt IF_ID_Instr", instr_b, e.instr);
        check(e.id, "alt IF_ID_PCPlus4", pc4_b, e.pc4);
        check(e.id, "alt IF_ID_Valid", {31'b0, vld_b}, {31'b0, e.vld});
        check(e.id, "alt IF_ID_Rs", {27'b0, rs_b}, {27'b0, e.rs});
        check(e.id, "alt IF_ID_Rt", {27'b0, rt_b}, {27'b0, e.rt});
        check(e.id, "alt ID_EX_Ctrl", {23'b0, ctrl_b}, {23'b0, e.ctrl});
        check(e.id, "alt StallCount", {29'b0, st_b}, {16'b0, e.st});
        check(e.id, "alt FlushCount", {29'b0, fl_b}, {16'b0, e.fl});
      end
    end
  end

  localparam logic [31:0] IA = 32'h0022_1820;
  localparam logic [31:0] IB = 32'h8C43_0004;
  localparam logic [31:0] IC = 32'h0064_2822;
  localparam logic [31:0] ID = 32'h03E0_0008;
  localparam logic [31:0] IE = 32'h1111_2222;
  localparam logic [31:0] IW = 32'h8D2A_0004;

  initial begin
    int guard;
    //  id rst pw iw cs fl  BranchTgt     Instr_in      Ctrl   alt  PC            Instr  PC+4          V  Ctrl   St Fl
    vec( 1, 0, 1, 1, 1, 1, 32'h0000_0040, 32'h1234_5678, 9'h1FF, 0, 32'h0000_0000, 32'h0, 32'h0000_0000, 0, 9'h000, 0, 0);
    vec( 2, 0, 1, 1, 1, 1, 32'h0000_0040, 32'h1234_5678, 9'h1FF, 0, 32'h0000_0000, 32'h0, 32'h0000_0000, 0, 9'h000, 0, 0);
    vec( 3, 1, 1, 1, 1, 0, 32'h0,         IA,            9'h0F0, 0, 32'h0000_0004, IA,    32'h0000_0004, 1, 9'h000, 0, 0);
    vec( 4, 1, 1, 1, 1, 0, 32'h0,         IB,            9'h155, 0, 32'h0000_0008, IB,    32'h0000_0008, 1, 9'h155, 0, 0);
    vec( 5, 1, 0, 0, 0, 0, 32'h0,         IC,            9'h0AA, 0, 32'h0000_0008, IB,    32'h0000_0008, 1, 9'h000, 1, 0);
    vec( 6, 1, 1, 1, 1, 0, 32'h0,         IC,            9'h0AA, 0, 32'h0000_000C, IC,    32'h0000_000C, 1, 9'h0AA, 1, 0);
    vec( 7, 1, 0, 0, 0, 1, 32'h0000_0103, 32'hFFFF_FFFF, 9'h1FF, 0, 32'h0000_0100, 32'h0, 32'h0000_0000, 0, 9'h000, 2, 1);
    vec( 8, 1, 1, 1, 1, 0, 32'h0,         ID,            9'h1FF, 0, 32'h0000_0104, ID,    32'h0000_0104, 1, 9'h000, 2, 1);
    vec( 9, 1, 1, 1, 1, 1, 32'h0000_0202, IE,            9'h0F0, 0, 32'h0000_0200, 32'h0, 32'h0000_0000, 0, 9'h0F0, 2, 2);
    vec(10, 1, 1, 0, 1, 0, 32'h0,         IE,            9'h033, 0, 32'h0000_0204, 32'h0, 32'h0000_0000, 0, 9'h000, 2, 2);
    vec(11, 1, 0, 1, 1, 0, 32'h0,         IE,            9'h033, 0, 32'h0000_0204, IE,    32'h0000_0208, 1, 9'h000, 2, 2);
    vec(12, 0, 0, 0, 0, 1, 32'h0000_0300, IE,            9'h033, 0, 32'h0000_0000, 32'h0, 32'h0000_0000, 0, 9'h000, 0, 0);
    // Wrap from FFFF_FFFC and Rs/Rt slicing on the alternate instance.
    vec(13, 1, 1, 1, 1, 0, 32'h0,         IW,            9'h1C3, 1, 32'h0000_0000, IW,    32'h0000_0000, 1, 9'h000, 0, 0);
    for (int k = 1; k <= 10; k++)
      vec(13 + k, 1, 0, 0, 0, 0, 32'h0,   IW,            9'h1C3, 1, 32'h0000_0000, IW,    32'h0000_0000, 1, 9'h000,
          (k > 7) ? 16'd7 : 16'(k), 0);
    vec(24, 0, 0, 0, 0, 0, 32'h0,         IW,            9'h1C3, 1, 32'hFFFF_FFFC, 32'h0, 32'h0000_0000, 0, 9'h000, 0, 0);

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      nbad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
